// File: rtl/data_sram_like_bridge.sv
// Bridges the core's single-cycle data-SRAM port onto the split-transaction sram-like bus.
// One transaction in flight; stall holds the pipeline until the cycle the result is released.
module data_sram_like_bridge #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [1:0]  READ_SIZE = 2'd2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sram_en,
    input  logic [3:0]        sram_wen,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_wdata,
    output logic [DATA_W-1:0] sram_rdata,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e            r_state;
    logic              r_req;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        w_size;

    // Unusual nonzero byte-enable patterns fall back to a full-word access.
    always_comb begin
        w_size = 2'd2;
        case (sram_wen)
            4'b0000:                            w_size = READ_SIZE;
            4'b0011, 4'b1100:                   w_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
            default:                            w_size = 2'd2;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (sram_en) begin
                        r_state <= StReq;
                        r_req   <= 1'b1;
                        r_wr    <= |sram_wen;
                        r_size  <= w_size;
                        r_addr  <= sram_addr;
                        r_wdata <= sram_wdata;
                    end
                end
                StReq: begin
                    if (bus_addr_ok) begin
                        r_req <= 1'b0;
                        if (bus_data_ok) begin
                            if (!r_wr) r_rdata <= bus_rdata;
                            r_state <= StDone;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus_data_ok) begin
                        if (!r_wr) r_rdata <= bus_rdata;
                        r_state <= StDone;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus_req    = r_req;
    assign bus_wr     = r_wr;
    assign bus_size   = r_size;
    assign bus_addr   = r_addr;
    assign bus_wdata  = r_wdata;
    assign sram_rdata = r_rdata;
    // DONE is the single release cycle for the pipeline.
    assign stall      = sram_en & (r_state != StDone);

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed, table-driven bench for data_sram_like_bridge.
module tb_data_sram_like_bridge;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int n_pass;
    int n_total;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ao_wait;
        bit          same;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];
    vec_t b2b  [2];
    vec_t post;

    data_sram_like_bridge #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .READ_SIZE (2'd2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sram_en     (sram_en),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .stall       (stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one access from the IDLE cycle through DONE; caller decides what follows DONE.
    task automatic txn(input vec_t v, input string tag);
        sram_en     = 1'b1;
        sram_wen    = v.wen;
        sram_addr   = v.addr;
        sram_wdata  = v.wdata;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        @(negedge clk);
        check({tag, " idle stall"}, 32'(stall), 32'd1);
        check({tag, " idle req"}, 32'(bus_req), 32'd0);
        for (int k = 0; k <= v.ao_wait; k++) begin
            cyc();
            if (k == v.ao_wait) begin
                bus_addr_ok = 1'b1;
                bus_data_ok = v.same;
                bus_rdata   = v.rdata;
            end
            @(negedge clk);
            check({tag, " req"}, 32'(bus_req), 32'd1);
            check({tag, " wr"}, 32'(bus_wr), 32'(v.wr));
            check({tag, " size"}, 32'(bus_size), 32'(v.size));
            check({tag, " addr"}, bus_addr, v.addr);
            check({tag, " wdata"}, bus_wdata, v.wdata);
            check({tag, " req stall"}, 32'(stall), 32'd1);
        end
        if (!v.same) begin
            cyc();
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b1;
            bus_rdata   = v.rdata;
            @(negedge clk);
            check({tag, " wait req"}, 32'(bus_req), 32'd0);
            check({tag, " wait stall"}, 32'(stall), 32'd1);
        end
        cyc();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = ~v.rdata;
        @(negedge clk);
        check({tag, " done stall"}, 32'(stall), 32'd0);
        check({tag, " done rdata"}, sram_rdata, v.exp_rd);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        //         wen      addr          wdata         rdata         ao same size  wr    exp_rd
        vecs[0] = '{4'b0000, 32'h1FC0_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0, 2'd2, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{4'b0100, 32'h0000_0102, 32'h00AB_0000, 32'h5555_5555, 3, 1'b0, 2'd0, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{4'b0000, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678, 0, 1'b1, 2'd2, 1'b0, 32'h1234_5678};
        vecs[3] = '{4'b0101, 32'h0000_0080, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1, 1'b1, 2'd2, 1'b1, 32'h1234_5678};
        vecs[4] = '{4'b0011, 32'h0000_0200, 32'h0000_BEEF, 32'h0000_0000, 0, 1'b0, 2'd1, 1'b1, 32'h1234_5678};
        vecs[5] = '{4'b0001, 32'h0000_0203, 32'h0000_00EE, 32'h6666_6666, 2, 1'b0, 2'd0, 1'b1, 32'h1234_5678};
        vecs[6] = '{4'b1000, 32'h0000_0207, 32'hEE00_0000, 32'h6666_6666, 0, 1'b0, 2'd0, 1'b1, 32'h1234_5678};
        vecs[7] = '{4'b1111, 32'h0000_0208, 32'hCAFE_F00D, 32'h3333_3333, 0, 1'b1, 2'd2, 1'b1, 32'h1234_5678};
        vecs[8] = '{4'b0000, 32'h8000_0003, 32'h0000_0000, 32'h0BAD_F00D, 2, 1'b0, 2'd2, 1'b0, 32'h0BAD_F00D};
        vecs[9] = '{4'b0111, 32'h0000_0300, 32'h0011_2233, 32'h4444_4444, 0, 1'b0, 2'd2, 1'b1, 32'h0BAD_F00D};
        b2b[0]  = '{4'b1100, 32'h0000_0304, 32'hABCD_0000, 32'h7777_7777, 0, 1'b0, 2'd1, 1'b1, 32'h0BAD_F00D};
        b2b[1]  = '{4'b0000, 32'h0000_0308, 32'h0000_0000, 32'h1357_9BDF, 0, 1'b0, 2'd2, 1'b0, 32'h1357_9BDF};
        post    = '{4'b0000, 32'h0000_0400, 32'h0000_0000, 32'hA5A5_0F0F, 1, 1'b0, 2'd2, 1'b0, 32'hA5A5_0F0F};

        resetn      = 1'b0;
        sram_en     = 1'b0;
        sram_wen    = 4'b0;
        sram_addr   = 32'h0;
        sram_wdata  = 32'h0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        @(negedge clk);
        check("rst req", 32'(bus_req), 32'd0);
        check("rst wr", 32'(bus_wr), 32'd0);
        check("rst size", 32'(bus_size), 32'd0);
        check("rst addr", bus_addr, 32'd0);
        check("rst wdata", bus_wdata, 32'd0);
        check("rst rdata", sram_rdata, 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        cyc();
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc();
            txn(vecs[i], $sformatf("v%0d", i));
            cyc();
            sram_en = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d after stall", i), 32'(stall), 32'd0);
            check($sformatf("v%0d after req", i), 32'(bus_req), 32'd0);
            check($sformatf("v%0d hold rdata", i), sram_rdata, vecs[i].exp_rd);
        end

        // Half-word write then word read with sram_en held: IDLE cycle then req.
        cyc();
        txn(b2b[0], "b2b0");
        cyc();
        txn(b2b[1], "b2b1");
        cyc();
        sram_en = 1'b0;
        @(negedge clk);
        check("b2b end stall", 32'(stall), 32'd0);

        // Reset in WAIT, then a stray data_ok that must be ignored.
        cyc();
        sram_en   = 1'b1;
        sram_wen  = 4'b0000;
        sram_addr = 32'h0000_2000;
        cyc();
        bus_addr_ok = 1'b1;
        @(negedge clk);
        check("rw req", 32'(bus_req), 32'd1);
        cyc();
        bus_addr_ok = 1'b0;
        sram_en     = 1'b0;
        resetn      = 1'b0;
        @(negedge clk);
        check("rw rst req", 32'(bus_req), 32'd0);
        check("rw rst size", 32'(bus_size), 32'd0);
        check("rw rst addr", bus_addr, 32'd0);
        check("rw rst rdata", sram_rdata, 32'd0);
        check("rw rst stall", 32'(stall), 32'd0);
        cyc();
        resetn      = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h9999_9999;
        @(negedge clk);
        check("rw stray req", 32'(bus_req), 32'd0);
        cyc();
        bus_data_ok = 1'b0;
        @(negedge clk);
        check("rw stray rdata", sram_rdata, 32'd0);
        check("rw stray stall", 32'(stall), 32'd0);
        cyc();
        txn(post, "post");
        cyc();
        sram_en = 1'b0;
        @(negedge clk);
        check("post idle req", 32'(bus_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
